// File: rtl/store_write_buffer_pkg.sv
// Shared types for the posted-store write buffer: length codes, drain states
// and the stored entry layout.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_len_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } wb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    mem_len_t             len;
  } wb_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Bundle of the store, load-snoop, fence and memory-write signals of the
// write buffer. The buffer uses the slave view; its environment the master.
interface store_write_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [1:0]        st_len;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_conflict;

  logic              drain;
  logic              busy;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_len;
  logic              mem_ack;

  logic              empty;
  logic              full;

  modport slave (
    input  st_valid, st_addr, st_data, st_len, ld_valid, ld_addr, drain, mem_ack,
    output st_ready, ld_hit, ld_data, ld_conflict, busy, mem_req, mem_addr, mem_wdata,
           mem_len, empty, full
  );

  modport master (
    output st_valid, st_addr, st_data, st_len, ld_valid, ld_addr, drain, mem_ack,
    input  st_ready, ld_hit, ld_data, ld_conflict, busy, mem_req, mem_addr, mem_wdata,
           mem_len, empty, full
  );
endinterface

// File: rtl/store_write_buffer_match.sv
// Load snoop: youngest-first search of the live entries for a word-address
// match. Word-sized matches forward, narrower ones report a conflict.
module wb_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH) + 1
) (
  input  wb_entry_t            entries [DEPTH],
  input  logic [PW-1:0]        head,
  input  logic [PW-1:0]        tail,
  input  logic [WB_ADDR_W-1:0] ld_addr,
  output logic                 hit,
  output logic                 conflict,
  output logic [WB_DATA_W-1:0] data
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [PW-1:0]        count;
  logic                 found;
  mem_len_t             found_len;
  logic [WB_DATA_W-1:0] found_data;
  logic [IW-1:0]        idx;
  logic                 unused_lsb;

  assign count = tail - head;

  // Walk from the entry just behind tail toward head; the first match is youngest.
  always_comb begin
    found      = 1'b0;
    found_len  = BYTE;
    found_data = '0;
    idx        = '0;
    unused_lsb = ^ld_addr[1:0];
    for (int k = 0; k < int'(DEPTH); k++) begin
      unused_lsb = unused_lsb ^ (^entries[k].addr[1:0]);
      idx = tail[IW-1:0] - IW'(k) - IW'(1);
      if (!found && (PW'(k) < count) && entries[idx].valid &&
          (entries[idx].addr[WB_ADDR_W-1:2] == ld_addr[WB_ADDR_W-1:2])) begin
        found      = 1'b1;
        found_len  = entries[idx].len;
        found_data = entries[idx].data;
      end
    end
  end

  assign hit      = found && (found_len == WORD);
  assign conflict = found && (found_len != WORD);
  assign data     = hit ? found_data : '0;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between MEM and data memory: single-cycle store retire,
// in-order drain over req/ack, and load snooping for forward or stall.
module store_write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input logic                  clk,
  input logic                  rst,
  store_write_buffer_if.slave  bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  wb_entry_t     entries_q [DEPTH];
  wb_entry_t     head_entry;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW-1:0] count;
  logic [PW-1:0] count_after;
  wb_state_t     state_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  logic                 snoop_hit;
  logic                 snoop_conflict;
  logic [WB_DATA_W-1:0] snoop_data;

  // The extra pointer MSB separates full from empty.
  assign count       = tail_q - head_q;
  assign empty       = (count == '0);
  assign full        = (count == PW'(DEPTH));
  assign push        = bus.st_valid && !full;
  assign pop         = (state_q == ISSUE) && bus.mem_ack;
  assign count_after = count - PW'(pop) + PW'(push);
  assign head_entry  = entries_q[head_q[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (pop) begin
        entries_q[head_q[IW-1:0]].valid <= 1'b0;
        head_q <= head_q + PW'(1);
      end
      // A push never lands on the head slot while it is being popped: full blocks it.
      if (push) begin
        entries_q[tail_q[IW-1:0]] <= '{valid: 1'b1,
                                       addr:  bus.st_addr,
                                       data:  bus.st_data,
                                       len:   mem_len_t'(bus.st_len)};
        tail_q <= tail_q + PW'(1);
      end
      unique case (state_q)
        IDLE:    if (!empty) state_q <= ISSUE;
        ISSUE:   if (pop && (count_after == '0)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  wb_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .entries  (entries_q),
    .head     (head_q),
    .tail     (tail_q),
    .ld_addr  (bus.ld_addr),
    .hit      (snoop_hit),
    .conflict (snoop_conflict),
    .data     (snoop_data)
  );

  assign bus.ld_hit      = bus.ld_valid && snoop_hit;
  assign bus.ld_conflict = bus.ld_valid && snoop_conflict;
  assign bus.ld_data     = bus.ld_valid ? DATA_W'(snoop_data) : '0;

  assign bus.st_ready  = !full;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.busy      = bus.drain && !empty;
  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_addr  = ADDR_W'(head_entry.addr);
  assign bus.mem_wdata = DATA_W'(head_entry.data);
  assign bus.mem_len   = head_entry.len;

endmodule
